// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pkg
// Purpose  : Shared FPU format constants, status codes and feeder FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    typedef enum logic [3:0] {
        EXACT     = 4'd0,
        OVERFLOW  = 4'd1,
        UNDERFLOW = 4'd2,
        INEXACT   = 4'd3
    } fpu_status_t;

    // 1 sign / 10 exponent / 21 fraction layout of the 32-bit FPU word
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 21;
    localparam int FRAC_W   = 21;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        HOLD    = 3'd2,
        CAPTURE = 3'd3,
        OUTPUT  = 3'd4
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/fpu_operand_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fpu_operand_fifo
// Purpose  : Synchronous FIFO of {op_a, op_b} pairs with full/empty/count.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_operand_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clock_100Khz,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == (c_ptr_w+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rd_data   = r_mem[r_rd_ptr];
    // No pass-through: a push is refused while full even if a pop coincides
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clock_100Khz) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock_100Khz) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/fpu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_operand_sequencer
// Purpose  : Queues operand pairs, holds each on the FPU for a settle window,
//            then captures the FPU result and offers it on valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_operand_sequencer
    import fpu_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 64,
    parameter int CNT_W       = 7
) (
    input  logic                   clock_100Khz,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_op_a,
    input  logic [31:0]            in_op_b,
    output logic [31:0]            Op_A_out,
    output logic [31:0]            Op_B_out,
    input  logic [31:0]            fpu_data_in,
    input  logic [3:0]             fpu_status_in,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [31:0]            res_data,
    output logic [3:0]             res_status,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_CYCLES - 1);

    feeder_state_t    r_state;
    feeder_state_t    w_next_state;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [63:0]      w_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_load;
    logic             w_capture;
    logic             w_accept;

    fpu_operand_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clock_100Khz (clock_100Khz),
        .reset        (reset),
        .push         (in_valid),
        .pop          (w_load),
        .wr_data      ({in_op_a, in_op_b}),
        .rd_data      (w_head),
        .full         (w_fifo_full),
        .empty        (w_fifo_empty),
        .count        (fifo_count)
    );

    assign in_ready = !w_fifo_full;
    assign busy     = (r_state != IDLE);

    always_ff @(posedge clock_100Khz) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE:    if (!w_fifo_empty) w_next_state = LOAD;
            LOAD: begin
                w_load       = 1'b1;
                w_next_state = HOLD;
            end
            HOLD:    if (r_hold_cnt == c_hold_last) w_next_state = CAPTURE;
            CAPTURE: begin
                w_capture    = 1'b1;
                w_next_state = OUTPUT;
            end
            OUTPUT: begin
                if (res_valid && res_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operands persist until the next LOAD so the FPU never sees a glitch
    always_ff @(posedge clock_100Khz) begin
        if (reset) begin
            r_hold_cnt <= '0;
            Op_A_out   <= '0;
            Op_B_out   <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_status <= EXACT;
        end else begin
            if (w_load) begin
                Op_A_out   <= w_head[63:32];
                Op_B_out   <= w_head[31:0];
                r_hold_cnt <= '0;
            end else if (r_state == HOLD) begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end

            if (w_capture) begin
                res_data   <= fpu_data_in;
                res_status <= fpu_status_in;
                res_valid  <= 1'b1;
            end else if (w_accept) begin
                res_valid  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_operand_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fpu_operand_sequencer
// Purpose  : Directed, table-driven bench with an XOR FPU stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_operand_sequencer;

    localparam int c_latency = 67;
    localparam int c_spacing = 68;

    logic        clock_100Khz = 1'b0;
    logic        reset        = 1'b1;
    logic        in_valid     = 1'b0;
    logic        in_ready;
    logic [31:0] in_op_a      = '0;
    logic [31:0] in_op_b      = '0;
    logic [31:0] Op_A_out;
    logic [31:0] Op_B_out;
    logic [31:0] fpu_data_in;
    logic [3:0]  fpu_status_in;
    logic        res_valid;
    logic        res_ready    = 1'b1;
    logic [31:0] res_data;
    logic [3:0]  res_status;
    logic        busy;
    logic [2:0]  fifo_count;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_push_cyc = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic [3:0]  exp_status;
    } vec_t;

    vec_t vecs [4];

    assign fpu_data_in   = Op_A_out ^ Op_B_out;
    assign fpu_status_in = Op_A_out[3:0];

    fpu_operand_sequencer #(
        .DEPTH       (4),
        .HOLD_CYCLES (64),
        .CNT_W       (7)
    ) dut (
        .clock_100Khz  (clock_100Khz),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op_a       (in_op_a),
        .in_op_b       (in_op_b),
        .Op_A_out      (Op_A_out),
        .Op_B_out      (Op_B_out),
        .fpu_data_in   (fpu_data_in),
        .fpu_status_in (fpu_status_in),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_status    (res_status),
        .busy          (busy),
        .fifo_count    (fifo_count)
    );

    always #5 clock_100Khz = ~clock_100Khz;
    always @(posedge clock_100Khz) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock_100Khz);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        in_op_a  = a;
        in_op_b  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        last_push_cyc = cyc;
    endtask

    task automatic wait_result(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (res_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic expect_result(input string name, input logic [31:0] a,
                                 input logic [31:0] b, output int at_cyc);
        bit f;
        wait_result(300, f);
        at_cyc = cyc;
        check({name, " valid"}, 32'(f), 32'd1);
        check({name, " data"}, res_data, a ^ b);
        check({name, " status"}, 32'(res_status), 32'(a[3:0]));
    endtask

    initial begin
        bit          f;
        int          p;
        int          t [6];
        int          bad;
        logic [31:0] held;

        vecs[0] = '{32'h3FE00000, 32'h40000000, 32'h7FE00000, 4'h0};
        vecs[1] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 4'hF};
        vecs[2] = '{32'h80000000, 32'h80000000, 32'h00000000, 4'h0};
        vecs[3] = '{32'h12345678, 32'h0F0F0F0F, 32'h1D3B5977, 4'h8};

        // reset values
        tick();
        tick();
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst fifo_count", 32'(fifo_count), 32'd0);
        check("rst Op_A_out", Op_A_out, 32'd0);
        check("rst Op_B_out", Op_B_out, 32'd0);
        check("rst res_valid", 32'(res_valid), 32'd0);
        check("rst res_data", res_data, 32'd0);
        check("rst res_status", 32'(res_status), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        // single pairs: latency, data, status, handshake
        for (int i = 0; i < 4; i++) begin
            push(vecs[i].a, vecs[i].b);
            p = last_push_cyc;
            wait_result(100, f);
            check($sformatf("vec%0d valid", i), 32'(f), 32'd1);
            check($sformatf("vec%0d latency", i), 32'(cyc - p), 32'(c_latency));
            check($sformatf("vec%0d data", i), res_data, vecs[i].exp_data);
            check($sformatf("vec%0d status", i), 32'(res_status), 32'(vecs[i].exp_status));
            tick();
            check($sformatf("vec%0d handshake", i), 32'(res_valid), 32'd0);
            check($sformatf("vec%0d res_data held", i), res_data, vecs[i].exp_data);
        end

        // ordering and result spacing
        push(32'h1, 32'h2);
        p = last_push_cyc;
        push(32'h3, 32'h4);
        push(32'h5, 32'h8);
        expect_result("ord0", 32'h1, 32'h2, t[0]);
        check("ord0 latency", 32'(t[0] - p), 32'(c_latency));
        expect_result("ord1", 32'h3, 32'h4, t[1]);
        expect_result("ord2", 32'h5, 32'h8, t[2]);
        check("ord spacing 0-1", 32'(t[1] - t[0]), 32'(c_spacing));
        check("ord spacing 1-2", 32'(t[2] - t[1]), 32'(c_spacing));

        // fill FIFO while HOLD runs, then a refused push
        push(32'h10, 32'h20);
        for (int i = 0; i < 5; i++) tick();
        check("fill busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 4; i++) push(32'h100 + 32'(i), 32'h0F0 + 32'(i));
        check("fill count", 32'(fifo_count), 32'd4);
        check("fill in_ready", 32'(in_ready), 32'd0);
        in_op_a  = 32'hDEAD0005;
        in_op_b  = 32'hBEEF0005;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("full push refused", 32'(fifo_count), 32'd4);
        expect_result("fill0", 32'h10, 32'h20, t[0]);
        for (int i = 1; i <= 4; i++) begin
            expect_result($sformatf("fill%0d", i), 32'h100 + 32'(i), 32'h0F0 + 32'(i), t[i]);
            check($sformatf("fill spacing %0d", i), 32'(t[i] - t[i-1] >= c_spacing), 32'd1);
        end
        wait_result(150, f);
        check("refused pair absent", 32'(f), 32'd0);
        check("fill drained", 32'(fifo_count), 32'd0);

        // downstream stall
        res_ready = 1'b0;
        push(32'h55AA0001, 32'h00FF00FF);
        expect_result("stall0", 32'h55AA0001, 32'h00FF00FF, t[0]);
        held = res_data;
        push(32'h00000007, 32'h00000070);
        check("stall count 1", 32'(fifo_count), 32'd1);
        push(32'h0000000C, 32'h000000C0);
        check("stall count 2", 32'(fifo_count), 32'd2);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (res_valid !== 1'b1 || res_data !== held || Op_A_out !== 32'h55AA0001) bad++;
        end
        check("stall stable cycles bad", 32'(bad), 32'd0);
        check("stall busy", 32'(busy), 32'd1);
        check("stall count held", 32'(fifo_count), 32'd2);
        res_ready = 1'b1;
        expect_result("stall1", 32'h00000007, 32'h00000070, t[1]);
        expect_result("stall2", 32'h0000000C, 32'h000000C0, t[2]);

        // reset in the middle of HOLD with two pairs queued
        push(32'hA0000001, 32'h0000000A);
        push(32'hA0000002, 32'h0000000B);
        push(32'hA0000003, 32'h0000000C);
        for (int i = 0; i < 10; i++) tick();
        check("mid busy", 32'(busy), 32'd1);
        check("mid count", 32'(fifo_count), 32'd2);
        check("mid Op_A_out", Op_A_out, 32'hA0000001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mreset count", 32'(fifo_count), 32'd0);
        check("mreset res_valid", 32'(res_valid), 32'd0);
        check("mreset Op_A_out", Op_A_out, 32'd0);
        check("mreset Op_B_out", Op_B_out, 32'd0);
        check("mreset busy", 32'(busy), 32'd0);
        check("mreset in_ready", 32'(in_ready), 32'd1);
        wait_result(200, f);
        check("no stale result", 32'(f), 32'd0);
        check("stays idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
